cdc_handshake_dest: RTL

Destination-side endpoint of a four-phase request/acknowledge clock-domain crossing for multi-bit words. Sits in the destination clock domain. It receives an asynchronous request and a held-stable data bus from a source-domain sender, and synchronizes the request through a flop chain. It captures the bus into a register, presents the word to local logic, and returns a registered acknowledge that the source domain synchronizes on its side.

---
 rtl/cdc_handshake_dest.sv | 122 ++++++++++++
 1 files changed

// File: rtl/cdc_handshake_dest.sv
// Destination endpoint of a four-phase request/acknowledge CDC for multi-bit words.
// Define CDC_HS_DEST_EXT_ACK_EN to gate the source acknowledge on the local dest_ack (adds VALID).
module cdc_handshake_dest #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             dest_clk,
    input  logic             dest_rst_n,
    input  logic             src_send,
    input  logic [WIDTH-1:0] src_in,
    output logic             src_rcv,
    output logic [WIDTH-1:0] dest_out,
    output logic             dest_req,
    input  logic             dest_ack,
    output logic             dest_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        VALID = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_req_sync;
    logic [WIDTH-1:0]       r_data;
    logic                   r_req;
    logic                   r_rcv;
    logic                   r_err;
    logic                   w_capture;
    logic                   w_req_nxt;
    logic                   w_rcv_nxt;
    logic                   w_err_nxt;

    // src_send is the only signal crossing asynchronously; src_in is qualified by it.
    always_ff @(posedge dest_clk or negedge dest_rst_n) begin
        if (!dest_rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], src_send};
        end
    end

    assign w_req_sync = r_sync[SYNC_STAGES-1];

`ifndef CDC_HS_DEST_EXT_ACK_EN
    logic w_unused_ack;
    assign w_unused_ack = dest_ack;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_req_nxt   = r_req;
        w_rcv_nxt   = r_rcv;
        w_err_nxt   = r_err;
        case (r_state)
            IDLE: begin
                if (w_req_sync) begin
                    w_capture = 1'b1;
                    w_req_nxt = 1'b1;
`ifdef CDC_HS_DEST_EXT_ACK_EN
                    w_state_nxt = VALID;
`else
                    w_rcv_nxt   = 1'b1;
                    w_state_nxt = ACK;
`endif
                end
            end
`ifdef CDC_HS_DEST_EXT_ACK_EN
            VALID: begin
                // An early request withdrawal outranks a same-cycle local ack.
                if (!w_req_sync) begin
                    w_err_nxt   = 1'b1;
                    w_req_nxt   = 1'b0;
                    w_state_nxt = IDLE;
                end else if (dest_ack) begin
                    w_req_nxt   = 1'b0;
                    w_rcv_nxt   = 1'b1;
                    w_state_nxt = ACK;
                end
            end
`endif
            ACK: begin
                w_req_nxt = 1'b0;
                if (!w_req_sync) begin
                    w_rcv_nxt   = 1'b0;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge dest_clk or negedge dest_rst_n) begin
        if (!dest_rst_n) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
            r_rcv   <= 1'b0;
            r_err   <= 1'b0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_req   <= w_req_nxt;
            r_rcv   <= w_rcv_nxt;
            r_err   <= w_err_nxt;
            if (w_capture) begin
                r_data <= src_in;
            end
        end
    end

    assign src_rcv  = r_rcv;
    assign dest_out = r_data;
    assign dest_req = r_req;
    assign dest_err = r_err;

endmodule
